// File: rtl/conv_enc_ctrl_if.sv
// rtl/conv_enc_ctrl_if.sv - information bit stream in, code word stream out
interface conv_enc_ctrl_if #(
  parameter int MAX_CODE_RATE = 3
);
  logic                     i_bit_valid;
  logic                     i_bit;
  logic                     o_bit_ready;
  logic                     o_code_valid;
  logic [MAX_CODE_RATE-1:0] o_code_word;

  modport master (
    output i_bit_valid, i_bit,
    input  o_bit_ready, o_code_valid, o_code_word
  );

  modport slave (
    input  i_bit_valid, i_bit,
    output o_bit_ready, o_code_valid, o_code_word
  );
endinterface

// File: rtl/conv_enc_ctrl.sv
// rtl/conv_enc_ctrl.sv - frame sequencer for conv_encoder (config check, bit feed, tail, drain)
// CONV_TAIL_EN: when defined, K-1 zero tail steps terminate the trellis.
module conv_enc_ctrl #(
  parameter int MAX_CODE_RATE = 3,
  parameter int MAX_K         = 9,
  parameter int LEN_W         = 16,
  parameter int ENC_LAT       = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_start,
  input  logic [1:0]                     i_code_rate,
  input  logic [3:0]                     i_constr_len,
  input  logic [MAX_CODE_RATE*MAX_K-1:0] i_gen_poly,
  input  logic                           i_mode_sel,
  input  logic [LEN_W-1:0]               i_frame_len,
  output logic                           o_en_c,
  output logic                           o_encoder_bit,
  output logic [1:0]                     o_code_rate,
  output logic [3:0]                     o_constr_len,
  output logic [MAX_CODE_RATE*MAX_K-1:0] o_gen_poly,
  output logic                           o_mode_sel,
  input  logic [MAX_CODE_RATE-1:0]       i_encoder_data,
  output logic                           o_busy,
  output logic                           o_frame_done,
  output logic                           o_cfg_err,
  conv_enc_ctrl_if.slave                 bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    TAIL  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t               state;
  logic [LEN_W-1:0]     frame_len;
  logic [LEN_W-1:0]     data_cnt;
  logic [7:0]           drain_cnt;
  logic                 bit_ready;
  logic                 en_last;
  logic [ENC_LAT-1:0]   en_pipe;
  logic [ENC_LAT-1:0]   last_pipe;
  logic                 cfg_ok;
  logic [MAX_CODE_RATE-1:0] code_word;
`ifdef CONV_TAIL_EN
  logic [3:0]           tail_cnt;
`endif

  // Checks the latched copy, so LOAD judges exactly what the encoder will see.
  always_comb begin
    cfg_ok = 1'b1;
    if (o_code_rate != 2'd2 && o_code_rate != 2'd3) cfg_ok = 1'b0;
    if (int'(o_constr_len) < 3 || int'(o_constr_len) > MAX_K) cfg_ok = 1'b0;
    if (frame_len == '0) cfg_ok = 1'b0;
    for (int j = 0; j < MAX_CODE_RATE; j++) begin
      if (j < int'(o_code_rate)) begin
        if (o_gen_poly[j*MAX_K +: MAX_K] == '0) cfg_ok = 1'b0;
        for (int b = 0; b < MAX_K; b++) begin
          if (b >= int'(o_constr_len) && o_gen_poly[j*MAX_K + b]) cfg_ok = 1'b0;
        end
      end
    end
  end

  always_comb begin
    code_word = '0;
    if (en_pipe[ENC_LAT-1]) begin
      for (int j = 0; j < MAX_CODE_RATE; j++) begin
        if (j < int'(o_code_rate)) code_word[j] = i_encoder_data[j];
      end
    end
  end

  assign bus.o_bit_ready  = bit_ready;
  assign bus.o_code_valid = en_pipe[ENC_LAT-1];
  assign bus.o_code_word  = code_word;
  assign o_frame_done     = last_pipe[ENC_LAT-1];
  assign o_busy           = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      frame_len     <= '0;
      data_cnt      <= '0;
      drain_cnt     <= '0;
      bit_ready     <= 1'b0;
      en_last       <= 1'b0;
      en_pipe       <= '0;
      last_pipe     <= '0;
      o_en_c        <= 1'b0;
      o_encoder_bit <= 1'b0;
      o_code_rate   <= '0;
      o_constr_len  <= '0;
      o_gen_poly    <= '0;
      o_mode_sel    <= 1'b0;
      o_cfg_err     <= 1'b0;
`ifdef CONV_TAIL_EN
      tail_cnt      <= '0;
`endif
    end else begin
      o_cfg_err     <= 1'b0;
      o_en_c        <= 1'b0;
      o_encoder_bit <= 1'b0;
      en_last       <= 1'b0;
      // en_last rides alongside o_en_c so the done pulse lands on the last word
      en_pipe       <= (en_pipe << 1) | ENC_LAT'(o_en_c);
      last_pipe     <= (last_pipe << 1) | ENC_LAT'(en_last);
      case (state)
        IDLE: begin
          if (i_start) begin
            o_code_rate  <= i_code_rate;
            o_constr_len <= i_constr_len;
            o_gen_poly   <= i_gen_poly;
            o_mode_sel   <= i_mode_sel;
            frame_len    <= i_frame_len;
            data_cnt     <= '0;
            drain_cnt    <= '0;
`ifdef CONV_TAIL_EN
            tail_cnt     <= '0;
`endif
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (cfg_ok) begin
            bit_ready <= 1'b1;
            state     <= RUN;
          end else begin
            o_cfg_err <= 1'b1;
            state     <= IDLE;
          end
        end
        RUN: begin
          if (bus.i_bit_valid && bit_ready) begin
            o_en_c        <= 1'b1;
            o_encoder_bit <= bus.i_bit;
            if (data_cnt != frame_len) data_cnt <= data_cnt + LEN_W'(1);
            if (data_cnt == frame_len - LEN_W'(1)) begin
              bit_ready <= 1'b0;
`ifdef CONV_TAIL_EN
              state     <= TAIL;
`else
              en_last   <= 1'b1;
              state     <= DRAIN;
`endif
            end
          end
        end
`ifdef CONV_TAIL_EN
        TAIL: begin
          o_en_c   <= 1'b1;
          tail_cnt <= tail_cnt + 4'd1;
          if (tail_cnt == o_constr_len - 4'd2) begin
            en_last <= 1'b1;
            state   <= DRAIN;
          end
        end
`endif
        DRAIN: begin
          drain_cnt <= drain_cnt + 8'd1;
          if (drain_cnt == 8'(ENC_LAT)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_enc_ctrl.sv
// tb/tb_conv_enc_ctrl.sv - directed bench for conv_enc_ctrl with a behavioural encoder
module tb_conv_enc_ctrl;

`ifdef CONV_TAIL_EN
  localparam int TAIL = 1;
`else
  localparam int TAIL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [1:0]  i_code_rate;
  logic [3:0]  i_constr_len;
  logic [26:0] i_gen_poly;
  logic        i_mode_sel;
  logic [15:0] i_frame_len;
  logic        o_en_c, o_encoder_bit;
  logic [1:0]  o_code_rate;
  logic [3:0]  o_constr_len;
  logic [26:0] o_gen_poly;
  logic        o_mode_sel;
  logic [2:0]  i_encoder_data;
  logic        o_busy, o_frame_done, o_cfg_err;

  conv_enc_ctrl_if #(.MAX_CODE_RATE(3)) bif ();

  conv_enc_ctrl dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_code_rate(i_code_rate),
    .i_constr_len(i_constr_len), .i_gen_poly(i_gen_poly), .i_mode_sel(i_mode_sel),
    .i_frame_len(i_frame_len), .o_en_c(o_en_c), .o_encoder_bit(o_encoder_bit),
    .o_code_rate(o_code_rate), .o_constr_len(o_constr_len), .o_gen_poly(o_gen_poly),
    .o_mode_sel(o_mode_sel), .i_encoder_data(i_encoder_data), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_cfg_err(o_cfg_err), .bus(bif.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Behavioural encoder: register bit K-1 holds the current input, one cycle latency.
  logic [8:0] enc_state;
  logic [8:0] enc_full;
  assign enc_full = enc_state | (9'(o_encoder_bit) << (o_constr_len - 4'd1));

  function automatic logic [2:0] enc_word(input logic [8:0] r, input logic [26:0] g);
    logic [2:0] w;
    for (int j = 0; j < 3; j++) w[j] = ^(r & g[j*9 +: 9]);
    return w;
  endfunction

  always @(posedge clk) begin
    if (rst || !o_busy) begin
      enc_state <= '0;
    end else if (o_en_c) begin
      enc_state      <= enc_full >> 1;
      i_encoder_data <= enc_word(enc_full, o_gen_poly);
    end
  end

  int cyc = 0, en_cnt = 0, nw = 0, done_cnt = 0, done_word = 0, cfg_cnt = 0;
  int busy_cnt = 0, busy_rise = 0, last_en_cyc = 0, fall_cyc = 0;
  logic prev_busy = 1'b0;
  logic [2:0] words [256];

  always @(negedge clk) begin
    cyc++;
    if (o_en_c) begin en_cnt++; last_en_cyc = cyc; end
    if (bif.o_code_valid) begin
      if (nw < 256) words[nw] = bif.o_code_word;
      nw++;
    end
    if (o_frame_done) begin done_cnt++; done_word = nw; end
    if (o_cfg_err) cfg_cnt++;
    if (o_busy) busy_cnt++;
    if (o_busy && !prev_busy) busy_rise++;
    if (!o_busy && prev_busy) fall_cyc = cyc;
    prev_busy = o_busy;
  end

  task automatic start_frame(input logic [1:0] n, input logic [3:0] k, input logic [26:0] g,
                             input logic [15:0] len, input logic mode, input logic hold);
    @(negedge clk);
    i_code_rate  = n;
    i_constr_len = k;
    i_gen_poly   = g;
    i_frame_len  = len;
    i_mode_sel   = mode;
    i_start      = 1'b1;
    @(negedge clk);
    i_start      = hold;
  endtask

  task automatic feed(input logic [15:0] bits, input int len, input int gap);
    int idx = 0;
    int g = 0;
    int n = 0;
    while (idx < len && n < 400) begin
      if (g < gap) begin
        bif.i_bit_valid = 1'b0;
        g++;
      end else begin
        bif.i_bit_valid = 1'b1;
        bif.i_bit       = bits[idx];
        if (bif.o_bit_ready) begin idx++; g = 0; end
      end
      @(negedge clk);
      n++;
    end
    bif.i_bit_valid = 1'b0;
    bif.i_bit       = 1'b0;
    if (idx < len) begin
      total++; bad++;
      $display("FAIL feed_timeout accepted=%0d required=%0d", idx, len);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (o_busy && n < 200) begin @(negedge clk); n++; end
    total++;
    if (o_busy) begin bad++; $display("FAIL idle_timeout busy=%b required=0", o_busy); end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({o_busy, bif.o_bit_ready, o_en_c, o_encoder_bit, bif.o_code_valid, bif.o_code_word,
         o_frame_done, o_cfg_err} !== 10'd0) begin
      bad++; $display("FAIL reset_outputs got=%b required=0", {o_busy, bif.o_bit_ready, o_en_c,
        o_encoder_bit, bif.o_code_valid, bif.o_code_word, o_frame_done, o_cfg_err});
    end
    total++;
    if ({o_code_rate, o_constr_len, o_gen_poly, o_mode_sel} !== 34'd0) begin
      bad++; $display("FAIL reset_config got=%h required=0",
        {o_code_rate, o_constr_len, o_gen_poly, o_mode_sel});
    end
    rst = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_basic();
    logic [2:0] exp_w [6];
    int exp_n, b_nw, b_done, b_busy, b_en;
    exp_w = '{3'd3, 3'd1, 3'd0, 3'd2, 3'd2, 3'd3};
    exp_n = 4 + 2 * TAIL;
    b_nw = nw; b_done = done_cnt; b_busy = busy_cnt; b_en = en_cnt;
    start_frame(2'd2, 4'd3, {9'h1FF, 9'h005, 9'h007}, 16'd4, 1'b0, 1'b0);
    total++;
    if ({o_busy, bif.o_bit_ready} !== 2'b10) begin
      bad++; $display("FAIL basic_load_phase busy_ready=%b required=10", {o_busy, bif.o_bit_ready});
    end
    @(negedge clk);
    total++;
    if (bif.o_bit_ready !== 1'b1) begin
      bad++; $display("FAIL basic_ready_latency ready=%b required=1", bif.o_bit_ready);
    end
    feed(16'b1101, 4, 0);
    wait_idle();
    total++;
    if (nw - b_nw !== exp_n) begin
      bad++; $display("FAIL basic_word_count got=%0d required=%0d", nw - b_nw, exp_n);
    end
    for (int i = 0; i < exp_n; i++) begin
      total++;
      if (words[b_nw + i] !== exp_w[i]) begin
        bad++; $display("FAIL basic_word%0d got=%b required=%b", i, words[b_nw + i], exp_w[i]);
      end
    end
    total++;
    if (done_cnt - b_done !== 1 || done_word - b_nw !== exp_n) begin
      bad++; $display("FAIL basic_done pulses=%0d at_word=%0d required=1 at %0d",
        done_cnt - b_done, done_word - b_nw, exp_n);
    end
    total++;
    if (en_cnt - b_en !== exp_n) begin
      bad++; $display("FAIL basic_en_count got=%0d required=%0d", en_cnt - b_en, exp_n);
    end
    total++;
    if (busy_cnt - b_busy !== 7 + 2 * TAIL) begin
      bad++; $display("FAIL basic_busy_cycles got=%0d required=%0d", busy_cnt - b_busy, 7 + 2 * TAIL);
    end
    total++;
    if ({o_constr_len, o_gen_poly} !== {4'd3, 9'h1FF, 9'h005, 9'h007}) begin
      bad++; $display("FAIL basic_config_hold got=%h required=%h", {o_constr_len, o_gen_poly},
        {4'd3, 9'h1FF, 9'h005, 9'h007});
    end
  endtask

  task automatic test_gaps();
    logic [8:0] g0, g1, g2;
    logic [2:0] exp;
    int exp_n, b_nw, b_en;
    g0 = 9'h1A5; g1 = 9'h13C; g2 = 9'h1FF;
    exp_n = 1 + 8 * TAIL;
    b_nw = nw; b_en = en_cnt;
    start_frame(2'd3, 4'd9, {g2, g1, g0}, 16'd1, 1'b0, 1'b0);
    feed(16'b1, 1, 2);
    wait_idle();
    total++;
    if (en_cnt - b_en !== exp_n) begin
      bad++; $display("FAIL gaps_en_count got=%0d required=%0d", en_cnt - b_en, exp_n);
    end
    for (int i = 0; i < exp_n; i++) begin
      exp = {g2[8-i], g1[8-i], g0[8-i]};
      total++;
      if (words[b_nw + i] !== exp) begin
        bad++; $display("FAIL gaps_word%0d got=%b required=%b", i, words[b_nw + i], exp);
      end
    end
    total++;
    if (fall_cyc - last_en_cyc !== 2) begin
      bad++; $display("FAIL gaps_busy_fall got=%0d required=2", fall_cyc - last_en_cyc);
    end
  endtask

  task automatic test_illegal();
    logic [1:0]  tn [5];
    logic [3:0]  tk [5];
    logic [26:0] tg [5];
    logic [15:0] tl [5];
    int b_en, b_cfg;
    tn = '{2'd2, 2'd1, 2'd2, 2'd2, 2'd2};
    tk = '{4'd10, 4'd3, 4'd3, 4'd4, 4'd3};
    tg = '{{9'h0, 9'h005, 9'h007}, {9'h0, 9'h005, 9'h007}, {9'h0, 9'h000, 9'h007},
           {9'h0, 9'h005, 9'h027}, {9'h0, 9'h005, 9'h007}};
    tl = '{16'd4, 16'd4, 16'd4, 16'd4, 16'd0};
    b_en = en_cnt; b_cfg = cfg_cnt;
    for (int i = 0; i < 5; i++) begin
      start_frame(tn[i], tk[i], tg[i], tl[i], 1'b0, 1'b0);
      total++;
      if ({o_busy, o_cfg_err} !== 2'b10) begin
        bad++; $display("FAIL illegal%0d_load busy_err=%b required=10", i, {o_busy, o_cfg_err});
      end
      @(negedge clk);
      total++;
      if (o_cfg_err !== 1'b1) begin
        bad++; $display("FAIL illegal%0d_err cfg_err=%b required=1", i, o_cfg_err);
      end
      @(negedge clk);
      total++;
      if ({o_busy, o_cfg_err} !== 2'b00) begin
        bad++; $display("FAIL illegal%0d_after busy_err=%b required=00", i, {o_busy, o_cfg_err});
      end
    end
    @(posedge clk);
    total++;
    if (en_cnt - b_en !== 0 || cfg_cnt - b_cfg !== 5) begin
      bad++; $display("FAIL illegal_totals en=%0d err=%0d required en=0 err=5",
        en_cnt - b_en, cfg_cnt - b_cfg);
    end
  endtask

  task automatic test_reset_mid();
    int b_done;
    b_done = done_cnt;
    start_frame(2'd2, 4'd9, {9'h0, 9'h171, 9'h1ED}, 16'd2, 1'b1, 1'b0);
    feed(16'b11, 2, 0);
    for (int i = 0; i < 2 * TAIL; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({o_busy, bif.o_bit_ready, o_en_c, o_encoder_bit, bif.o_code_valid, bif.o_code_word,
         o_frame_done, o_cfg_err, o_code_rate, o_constr_len, o_gen_poly, o_mode_sel} !== 44'd0) begin
      bad++; $display("FAIL midreset_outputs got=%h required=0", {o_busy, bif.o_bit_ready, o_en_c,
        o_encoder_bit, bif.o_code_valid, bif.o_code_word, o_frame_done, o_cfg_err, o_code_rate,
        o_constr_len, o_gen_poly, o_mode_sel});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    total++;
    if (done_cnt - b_done !== 0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL midreset_no_done done=%0d busy=%b required 0 0", done_cnt - b_done, o_busy);
    end
  endtask

  task automatic test_start_held();
    int b_rise, b_done, b_nw, n;
    b_rise = busy_rise; b_done = done_cnt; b_nw = nw;
    start_frame(2'd3, 4'd5, {9'h017, 9'h01D, 9'h013}, 16'd3, 1'b1, 1'b1);
    total++;
    if ({o_mode_sel, o_code_rate} !== 3'b111) begin
      bad++; $display("FAIL held_config mode_rate=%b required=111", {o_mode_sel, o_code_rate});
    end
    feed(16'b010, 3, 0);
    n = 0;
    while (!o_frame_done && n < 100) begin @(negedge clk); n++; end
    i_start = 1'b0;
    total++;
    if (o_frame_done !== 1'b1) begin
      bad++; $display("FAIL held_done_timeout done=%b required=1", o_frame_done);
    end
    wait_idle();
    total++;
    if (busy_rise - b_rise !== 1 || done_cnt - b_done !== 1 || nw - b_nw !== 3 + 4 * TAIL) begin
      bad++; $display("FAIL held_no_restart frames=%0d done=%0d words=%0d required 1 1 %0d",
        busy_rise - b_rise, done_cnt - b_done, nw - b_nw, 3 + 4 * TAIL);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_start = 1'b0; i_code_rate = '0; i_constr_len = '0; i_gen_poly = '0;
    i_mode_sel = 1'b0; i_frame_len = '0;
    bif.i_bit_valid = 1'b0; bif.i_bit = 1'b0;
    i_encoder_data = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_illegal();
    test_reset_mid();
    test_basic();
    test_start_held();
    test_basic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_enc_ctrl.md
# conv_enc_ctrl

Frame-level controller that sequences `conv_encoder`. It latches and validates a configuration: code rate, constraint length, generator polynomials and mode. It then streams one information bit per cycle into the encoder from a valid/ready source, appends K-1 zero tail bits, collects the code words, and flags frame completion. It sits between the host/bit source and `conv_encoder`, and is the only block that drives the encoder's `en_c` and configuration inputs.

## Interface
Parameters:
- `MAX_CODE_RATE`, 3, maximum code word width (n), matches `MAX_CODE_RATE` in `param_def.v`
- `MAX_K`, 9, maximum constraint length, matches `MAX_CONSTRAINT_LENGTH`
- `LEN_W`, 16, frame-length counter width
- `ENC_LAT`, 1, cycles from `o_en_c` high to the matching valid `i_encoder_data`

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  **synchronous, active-high** reset
- `i_start`  in  1  request a frame; sampled only in IDLE
- `i_code_rate`  in  2  n: 2 = rate 1/2, 3 = rate 1/3
- `i_constr_len`  in  4  K, legal range 3..9
- `i_gen_poly`  in  MAX_CODE_RATE*MAX_K  polynomial g[j] at bits [j*MAX_K +: MAX_K]
- `i_mode_sel`  in  1  forwarded mode (0 = encode)
- `i_frame_len`  in  LEN_W  number of information bits, legal range ≥1
- `i_bit_valid`, `i_bit`  in  1, 1  information bit stream
- `o_bit_ready`  out  1  bit accepted when valid && ready
- `o_en_c`, `o_encoder_bit`  out  1, 1  encoder step enable and input bit
- `o_code_rate`, `o_constr_len`, `o_gen_poly`, `o_mode_sel`  out  —  latched configuration to the encoder
- `i_encoder_data`  in  MAX_CODE_RATE  encoder code word
- `o_code_valid`, `o_code_word`  out  1, MAX_CODE_RATE  code word stream; no backpressure
- `o_busy`  out  1  high outside IDLE
- `o_frame_done`  out  1  one-cycle pulse
- `o_cfg_err`  out  1  one-cycle pulse

## Operation
- States: IDLE → LOAD → RUN → TAIL → DRAIN → IDLE.
- IDLE:
  - On `i_start`, latch all configuration inputs and go to LOAD.
  - In LOAD, validate the latched configuration. The configuration is illegal if any of the following holds:
    - n ∉ {2,3}
    - K ∉ 3..9
    - `frame_len` = 0
    - any used g[j] (j < n) has a bit set at position ≥ K
    - any used g[j] is all-zero
  - Illegal configuration: pulse `o_cfg_err`, return to IDLE, issue no `o_en_c`.
  - Legal configuration: go to RUN.
- RUN:
  - `o_bit_ready` = 1.
  - On each handshake, register `o_en_c`=1 and `o_encoder_bit`=`i_bit` for the next cycle, and increment `data_cnt`.
  - No handshake: `o_en_c`=0 next cycle. Source gaps are allowed.
  - When `data_cnt` reaches `frame_len`, deassert ready and go to TAIL.
- TAIL: issue exactly K-1 consecutive steps with `o_en_c`=1 and `o_encoder_bit`=0, then go to DRAIN.
- DRAIN: wait ENC_LAT cycles for the last code word, then go to IDLE.
- Valid pipeline:
  - `o_en_c` is delayed ENC_LAT cycles into `o_code_valid`.
  - `o_code_word` = `i_encoder_data` when valid; unused upper bits (n=2) are forced to 0; all bits are 0 when not valid.
- `o_frame_done` pulses in the same cycle as the last code word.
- Code word count per frame = `frame_len` + K-1 exactly.
- Configuration outputs hold their latched values until the next LOAD, including while in IDLE.
- `i_start` outside IDLE is ignored.

## Timing
- Reset values: all outputs 0, except configuration outputs, which are also 0. Counters and pipeline clear; the state goes to IDLE.
- Reset mid-frame: on the next edge, in-flight code words are dropped, `o_en_c`=0, no `o_frame_done` pulse.
- Handshake-to-`o_en_c` latency: 1 cycle. `o_en_c`-to-`o_code_valid` latency: ENC_LAT cycles.
- `i_start` to first `o_bit_ready`: 2 cycles (IDLE→LOAD→RUN).
- Back-to-back source, from the cycle `o_busy` rises: the frame occupies 1 (LOAD) + `frame_len` + (K-1) + ENC_LAT cycles, plus the RUN→TAIL transition cycle.
- `o_frame_done` to the next accepted `i_start`: 1 cycle (IDLE must be reached first).
- `data_cnt` saturates at `frame_len` and never wraps; `frame_len` = 2^LEN_W-1 is legal.

## Configuration
- Macro: `CONV_TAIL_EN`.
- Defined: zero-tail termination as described; K-1 tail steps.
- Undefined: TAIL state removed; RUN goes directly to DRAIN; code word count = `frame_len` (truncated trellis).
- Validation and all other behaviour are identical in both builds.

## Test plan
- n=2, K=3, g={7,5}, frame_len=4, bits 1,0,1,1 back-to-back: 6 code words, 11,10,00,01,01,11; `o_frame_done` with the 6th.
- n=3, K=9, frame_len=1, `i_bit_valid` gaps of 2 cycles: exactly 9 `o_en_c` pulses; `o_code_word` upper bits tracked; `o_busy` falls ENC_LAT+1 cycles after the last `o_en_c`.
- Illegal configurations (K=10; n=1; g[1]=0; g[0] bit 5 set with K=4; frame_len=0): `o_cfg_err` pulse 2 cycles after `i_start`, zero `o_en_c`, `o_busy` low again.
- `rst` asserted during TAIL: next cycle all outputs 0; a following frame runs correctly.
- `i_start` held high during RUN: no restart; frame count unchanged.
- Build without `CONV_TAIL_EN`, repeating the first case: 4 code words 11,10,00,01; done pulse with the 4th.
